// File: rtl/aes_cipher_iter.sv
// Iterative AES encryption core: one full round per clock, fed by an external round-key schedule.
// Valid/ready handshakes on both plaintext input and ciphertext output.
module aes_cipher_iter #(
   parameter int unsigned Nk = 4,
   parameter int unsigned Nr = Nk + 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_block,
   input  logic [127:0] k_sch [0:Nr],
   output logic         busy,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_block
);

   typedef enum logic [1:0] {StIdle, StRound, StDone} state_t;

   state_t       state_q;
   logic [3:0]   rnd_q;
   logic [127:0] st_q;

   logic [127:0] sb, sr, mc, rnd_nxt;
   logic         last;

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   // Inverse as b^254 = prod of b^(2^k), k=1..7; zero maps to zero naturally.
   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [7:0] sq, inv;
      sq  = b;
      inv = 8'h01;
      for (int k = 1; k < 8; k++) begin
         sq  = gmul(sq, sq);
         inv = gmul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] mixcol(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      a0 = c[7:0];
      a1 = c[15:8];
      a2 = c[23:16];
      a3 = c[31:24];
      return {xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3),
              a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
              a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
              xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3};
   endfunction

   always_comb begin
      sb = '0;
      sr = '0;
      mc = '0;
      for (int i = 0; i < 16; i++) sb[8*i +: 8] = sbox(st_q[8*i +: 8]);
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) sr[32*c + 8*r +: 8] = sb[32*((c + r) % 4) + 8*r +: 8];
      end
      for (int c = 0; c < 4; c++) mc[32*c +: 32] = mixcol(sr[32*c +: 32]);
   end

   assign last    = (rnd_q == 4'(Nr));
   assign rnd_nxt = (last ? sr : mc) ^ k_sch[rnd_q];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         rnd_q   <= '0;
         st_q    <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  st_q    <= in_block ^ k_sch[0];
                  rnd_q   <= 4'd1;
                  state_q <= StRound;
               end
            end
            StRound: begin
               st_q <= rnd_nxt;
               if (last) state_q <= StDone;
               else      rnd_q   <= rnd_q + 4'd1;
            end
            StDone: begin
               if (out_ready) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign busy      = (state_q == StRound) || (state_q == StDone);
   assign out_valid = (state_q == StDone);
   assign out_block = st_q;

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Self-checking bench for aes_cipher_iter: FIPS vectors, random blocks against a byte-level
// AES model, backpressure, back-to-back throughput and asynchronous reset mid-round.
module tb_aes_cipher_iter;

   logic clk, rst;

   logic         in_valid4, in_ready4, busy4, out_valid4, out_ready4;
   logic [127:0] in_block4, out_block4;
   logic [127:0] ks4 [0:10];

   logic         in_valid8, in_ready8, busy8, out_valid8, out_ready8;
   logic [127:0] in_block8, out_block8;
   logic [127:0] ks8 [0:14];

   aes_cipher_iter #(.Nk(4)) u4 (
      .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .in_block(in_block4),
      .k_sch(ks4), .busy(busy4), .out_valid(out_valid4), .out_ready(out_ready4),
      .out_block(out_block4)
   );

   aes_cipher_iter #(.Nk(8)) u8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .in_block(in_block8),
      .k_sch(ks8), .busy(busy8), .out_valid(out_valid8), .out_ready(out_ready8),
      .out_block(out_block8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic [7:0]   sbox_t [0:255];
   logic [127:0] mrk [0:14];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Carry-less product then polynomial reduction by x^8+x^4+x^3+x+1.
   function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [7:0] m_sbox_calc(input int b);
      logic [7:0] inv, x, c;
      inv = 8'h00;
      c   = 8'h63;
      for (int y = 1; y < 256; y++) if (m_mul(8'(b), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
         x[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      return x;
   endfunction

   function automatic logic [31:0] m_subw(input logic [31:0] w);
      return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
   endfunction

   task automatic expand(input logic [255:0] key, input int nk);
      logic [31:0] w [0:59];
      logic [31:0] t;
      logic [7:0]  rc;
      int          nr;
      nr = nk + 6;
      rc = 8'h01;
      for (int i = 0; i < nk; i++) w[i] = key[32*i +: 32];
      for (int i = nk; i < 4 * (nr + 1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t  = m_subw({t[7:0], t[31:8]}) ^ {24'h0, rc};
            rc = m_mul(rc, 8'h02);
         end else if (nk > 6 && i % nk == 4) begin
            t = m_subw(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r <= nr; r++) mrk[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
      if (nk == 8) for (int r = 0; r <= 14; r++) ks8[r] = mrk[r];
      else         for (int r = 0; r <= 10; r++) ks4[r] = mrk[r];
   endtask

   function automatic logic [127:0] ref_enc(input logic [127:0] pt, input int nr);
      logic [7:0]   s [0:15];
      logic [7:0]   t [0:15];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] res;
      for (int i = 0; i < 16; i++) s[i] = pt[8*i +: 8] ^ mrk[0][8*i +: 8];
      for (int r = 1; r <= nr; r++) begin
         for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
         for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) s[4*c+row] = t[4*((c+row)%4)+row];
         if (r != nr) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = m_mul(8'h02, a0) ^ m_mul(8'h03, a1) ^ a2 ^ a3;
               s[4*c+1] = a0 ^ m_mul(8'h02, a1) ^ m_mul(8'h03, a2) ^ a3;
               s[4*c+2] = a0 ^ a1 ^ m_mul(8'h02, a2) ^ m_mul(8'h03, a3);
               s[4*c+3] = m_mul(8'h03, a0) ^ a1 ^ a2 ^ m_mul(8'h02, a3);
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ mrk[r][8*i +: 8];
      end
      for (int i = 0; i < 16; i++) res[8*i +: 8] = s[i];
      return res;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Starts at a negedge with the target idle; returns at the first negedge showing out_valid.
   task automatic run_block(input int which, input logic [127:0] pt,
                            output logic [127:0] ct, output int lat);
      if (which == 8) begin in_block8 = pt; in_valid8 = 1'b1; end
      else            begin in_block4 = pt; in_valid4 = 1'b1; end
      @(negedge clk);
      in_valid8 = 1'b0;
      in_valid4 = 1'b0;
      lat = 0;
      while (!((which == 8) ? out_valid8 : out_valid4) && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      if (lat >= 60) begin
         tests++;
         fails++;
         $display("FAIL run_block_timeout: got no out_valid within %0d cycles", lat);
      end
      ct = (which == 8) ? out_block8 : out_block4;
   endtask

   typedef struct {
      int           nk;
      logic [255:0] key;
      logic [127:0] pt;
      logic [127:0] exp;
   } vec_t;

   vec_t         vecs [0:2];
   logic [127:0] ct, pt, held;
   int           lat, n_acc, n_out, cyc, last_acc;
   logic         spurious;
   logic [127:0] expq [$];

   initial begin
      vecs[0] = '{4, {128'h0, 128'h0f0e0d0c0b0a09080706050403020100},
                  128'hffeeddccbbaa99887766554433221100, 128'h5ac5b47080b7cdd830047b6ad8e0c469};
      vecs[1] = '{8, 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100,
                  128'hffeeddccbbaa99887766554433221100, 128'h8960494b9049fceabf456751cab7a28e};
      vecs[2] = '{4, 256'h0, 128'h0, 128'h2e2b34ca59fa4c883b2c8aefd44be966};

      rst = 1'b1;
      in_valid4 = 1'b0; in_block4 = '0; out_ready4 = 1'b1;
      in_valid8 = 1'b0; in_block8 = '0; out_ready8 = 1'b1;
      for (int r = 0; r <= 10; r++) ks4[r] = '0;
      for (int r = 0; r <= 14; r++) ks8[r] = '0;
      for (int b = 0; b < 256; b++) sbox_t[b] = m_sbox_calc(b);

      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_in_ready", 128'(in_ready4), 128'd1);
      chk("reset_busy", 128'(busy4), 128'd0);
      chk("reset_out_valid", 128'(out_valid4), 128'd0);
      chk("reset_out_block", out_block4, 128'h0);
      chk("reset_in_ready8", 128'(in_ready8), 128'd1);

      // Known-answer vectors, including exact latency of Nr cycles.
      for (int v = 0; v < 3; v++) begin
         expand(vecs[v].key, vecs[v].nk);
         run_block(vecs[v].nk, vecs[v].pt, ct, lat);
         chk($sformatf("kat%0d_block", v), ct, vecs[v].exp);
         chk($sformatf("kat%0d_latency", v), 128'(lat), 128'(vecs[v].nk + 6));
         @(negedge clk);
         chk($sformatf("kat%0d_ready_after", v),
             128'((vecs[v].nk == 8) ? in_ready8 : in_ready4), 128'd1);
      end

      // Random keys and blocks on the 256-bit core.
      for (int k = 0; k < 3; k++) begin
         expand({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                8);
         pt = rnd128();
         run_block(8, pt, ct, lat);
         chk("rand8_block", ct, ref_enc(pt, 14));
         @(negedge clk);
      end

      // Backpressure: output and handshake state hold while out_ready is low.
      expand({128'h0, rnd128()}, 4);
      out_ready4 = 1'b0;
      pt = rnd128();
      run_block(4, pt, held, lat);
      chk("bp_block", held, ref_enc(pt, 10));
      for (int k = 0; k < 20; k++) begin
         in_valid4 = k[0];
         in_block4 = rnd128();
         @(negedge clk);
         chk("bp_hold_block", out_block4, held);
         chk("bp_hold_valid", 128'(out_valid4), 128'd1);
         chk("bp_in_ready", 128'(in_ready4), 128'd0);
      end
      in_valid4  = 1'b0;
      out_ready4 = 1'b1;
      @(negedge clk);
      chk("bp_release_valid", 128'(out_valid4), 128'd0);
      chk("bp_release_ready", 128'(in_ready4), 128'd1);
      @(negedge clk);
      chk("bp_idle_busy", 128'(busy4), 128'd0);

      // Back-to-back with in_valid and out_ready high: accepts exactly Nr+2 apart.
      expand({128'h0, rnd128()}, 4);
      in_valid4 = 1'b1;
      n_acc = 0; n_out = 0; cyc = 0; last_acc = 0;
      while (n_out < 8 && cyc < 300) begin
         if (out_valid4) begin
            if (expq.size() == 0) chk("b2b_unexpected_out", out_block4, 128'hx);
            else                  chk("b2b_block", out_block4, expq.pop_front());
            n_out++;
         end
         if (in_ready4) begin
            if (n_acc < 8) begin
               pt = rnd128();
               in_block4 = pt;
               expq.push_back(ref_enc(pt, 10));
               if (n_acc > 0) chk("b2b_spacing", 128'(cyc - last_acc), 128'd12);
               last_acc = cyc;
               n_acc++;
            end else begin
               in_valid4 = 1'b0;
            end
         end
         @(negedge clk);
         cyc++;
      end
      in_valid4 = 1'b0;
      chk("b2b_outputs_seen", 128'(n_out), 128'd8);
      @(negedge clk);

      // Asynchronous reset in the middle of round 5.
      in_block4 = rnd128();
      in_valid4 = 1'b1;
      @(negedge clk);
      in_valid4 = 1'b0;
      repeat (4) @(negedge clk);
      chk("mid_busy_before_rst", 128'(busy4), 128'd1);
      #2 rst = 1'b1;
      #1;
      chk("arst_in_ready", 128'(in_ready4), 128'd1);
      chk("arst_busy", 128'(busy4), 128'd0);
      chk("arst_out_valid", 128'(out_valid4), 128'd0);
      chk("arst_out_block", out_block4, 128'h0);
      @(negedge clk);
      rst = 1'b0;
      spurious = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (out_valid4) spurious = 1'b1;
      end
      chk("arst_no_spurious_valid", 128'(spurious), 128'd0);
      pt = rnd128();
      run_block(4, pt, ct, lat);
      chk("post_rst_block", ct, ref_enc(pt, 10));
      chk("post_rst_latency", 128'(lat), 128'd10);
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/aes_cipher_iter.md
# aes_cipher_iter

Iterative AES encryption core that consumes the round-key schedule produced by the key-expansion stage and encrypts one 128-bit block at a time, performing one full round per clock. It sits directly downstream of key expansion: the `k_sch` array feeds straight in, and the core exposes valid/ready handshakes on both the plaintext input and the ciphertext output. `busy` tells the key source when it must hold the schedule stable.

## Interface
- `Nk`, default 4: key length in 32-bit words. Legal values are 4, 6 and 8.
- `Nr`, default `Nk+6`: number of rounds.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  `in_block` is valid.
- `in_ready`  out  1  core can accept a block; equals (state == IDLE).
- `in_block`  in  128  plaintext. Column c is `[32*c+:32]`; row r of a column is `[8*r+:8]`; FIPS byte 0 is `[7:0]`.
- `k_sch`  in  128 x (Nr+1)  round keys `[0:Nr]`, same byte layout as `in_block`.
- `busy`  out  1  high in ROUND and DONE. The key source must hold `k_sch` stable while `busy` is high.
- `out_valid`  out  1  `out_block` holds a finished ciphertext.
- `out_ready`  in  1  downstream accepts `out_block`.
- `out_block`  out  128  ciphertext, same byte layout.

## Operation
- FSM states are IDLE, ROUND and DONE. Round counter `rnd` is 4 bits and counts 1..Nr.
- **IDLE:**
  - Accept occurs on `in_valid && in_ready`.
  - On accept: `st <= in_block ^ k_sch[0]`, `rnd <= 1`, next state ROUND.
- **ROUND:** every cycle, `st <= AddRoundKey(MixColumns(ShiftRows(SubBytes(st))), k_sch[rnd])`.
  - SubBytes uses the shared S-box (`SubWord` per column).
  - When `rnd == Nr`, MixColumns is skipped and the next state is DONE; otherwise `rnd <= rnd+1`.
- **ShiftRows:** row r rotates left by r columns. The new byte at (row r, column c) is the old byte at (r, (c+r) mod 4).
- **MixColumns:** standard GF(2^8) matrix [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2] per column.
  - xtime(b) = (b<<1) ^ (b[7] ? 8'h1b : 0), truncated to 8 bits.
  - Row index 0 is the low byte.
- **DONE:**
  - `out_valid = 1`, `out_block = st`.
  - On `out_ready`: next state IDLE and `out_valid` drops the following cycle.
- `in_valid` is ignored outside IDLE, and `in_block` is not sampled.
- While `out_valid && !out_ready`, `out_block` and `out_valid` hold unchanged indefinitely.
- `out_block` is driven from the state register; it is not recomputed.
- If `k_sch` changes while `busy` is high, the result is undefined. The bench does not check it.

## Timing
- Reset values:
  - state IDLE, `rnd` 0, `st` 0.
  - `in_ready` 1, `busy` 0, `out_valid` 0, `out_block` 128'h0.
- Reset during ROUND or DONE aborts the block. No `out_valid` is produced for it, and `in_ready` is 1 immediately after reset deasserts.
- Latency: accept at edge T. Rounds execute at edges T+1..T+Nr. `out_valid` rises after edge T+Nr, i.e. Nr cycles after accept.
- `in_ready` falls after edge T and rises again the cycle after the output handshake.
- Maximum throughput, with `out_ready` tied high, is one block per Nr+2 cycles (AES-128: 12).
- All outputs are registered or decoded from registered state. There is no combinational path from `in_valid` or `out_ready` to any output.
- Critical path: one round of S-box, MixColumns and XOR, from `st` back to `st`.

## Test plan
- **FIPS-197 C.1 (Nk=4):**
  - key 128'h0f0e0d0c0b0a09080706050403020100, pt 128'hffeeddccbbaa99887766554433221100.
  - Expect `out_block` = 128'h5ac5b47080b7cdd830047b6ad8e0c469, with `out_valid` exactly 10 cycles after accept.
- **FIPS-197 C.3 (Nk=8):**
  - key 256'h1f1e...0100, same pt.
  - Expect 128'h8960494b9049fceabf456751cab7a28e, 14 cycles after accept.
- **Backpressure:**
  - Hold `out_ready` = 0 for 20 cycles after `out_valid`.
  - Expect `out_block` and `out_valid` stable, `in_ready` = 0, and `in_valid` pulses ignored.
  - Release `out_ready`: one handshake, then `in_ready` = 1.
- **Back-to-back:**
  - `in_valid` and `out_ready` tied high, 8 random blocks.
  - Expect ciphertexts to match the reference model in order, with accepts spaced exactly Nr+2 cycles apart.
- **Reset mid-round:**
  - Assert `rst` asynchronously at round 5.
  - Expect all outputs at reset values within the same cycle and no spurious `out_valid`.
  - The next block encrypts correctly.
- **All-zero key and plaintext (Nk=4):** expect 128'h2e2b34ca59fa4c883b2c8aefd44be966 (66e94bd4ef8a2c3b884cfa59ca342b2e in FIPS byte order).
